// File: rtl/uart_program_loader.sv
// UART boot loader: receives a length header plus big-endian instruction words and writes them to instruction memory.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before load_done is raised.
module uart_program_loader #(
    parameter int unsigned CLK_FREQ_HZ = 100000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned DEPTH       = 32,
    parameter int unsigned ADDR_W      = 5
) (
    input  logic                   CLK,
    input  logic                   CPU_RESETN,
    input  logic                   UART_TXD_IN,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   load_done,
    output logic [ADDR_W:0]        word_count,
    output logic [1:0]             err_code
);

    localparam int unsigned DIV   = CLK_FREQ_HZ / BAUD;
    localparam int unsigned HALF  = DIV / 2;
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam int unsigned BYTES = INSTR_WIDTH / 8;
    localparam int unsigned BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {
        L_IDLE,
        L_DATA,
`ifdef LOADER_CHECKSUM_EN
        L_CSUM,
`endif
        L_DONE
    } ld_state_t;

    // ---------------- receiver ----------------
    rx_state_t        rx_state_q, rx_state_d;
    logic             sync1_q, sync2_q, line_prev_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             half_tick, bit_tick;

    assign half_tick = (rx_cnt_q == CNT_W'(HALF - 1));
    assign bit_tick  = (rx_cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            line_prev_q  <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync1_q      <= UART_TXD_IN;
            sync2_q      <= sync1_q;
            line_prev_q  <= sync2_q;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (line_prev_q && !sync2_q) rx_state_d = RX_START;
            RX_START: if (half_tick) rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (bit_tick) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_cnt_d     = rx_cnt_q + 1'b1;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: rx_cnt_d = '0;
            RX_START: begin
                if (half_tick) begin
                    rx_cnt_d  = '0;
                    bit_idx_d = '0;
                end
            end
            RX_DATA: begin
                if (bit_tick) begin
                    rx_cnt_d  = '0;
                    shift_d   = {sync2_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (bit_tick) begin
                    rx_cnt_d     = '0;
                    byte_valid_d = sync2_q;
                    frame_err_d  = !sync2_q;
                end
            end
            default: rx_cnt_d = '0;
        endcase
    end

    // ---------------- loader ----------------
    ld_state_t              state_q, state_d;
    logic [INSTR_WIDTH-1:0] word_q, word_d;
    logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [ADDR_W:0]        len_q, len_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   load_done_q, load_done_d;
    logic [ADDR_W:0]        word_count_q, word_count_d;
    logic [1:0]             err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             csum_q, csum_d;
`endif
    logic                   accept, hdr_seen, hdr_bad, last_byte, load_end;

    assign accept    = byte_valid_q && !wr_en_q;
    assign hdr_seen  = accept && (shift_q != '0);
    assign hdr_bad   = (shift_q > 8'(DEPTH));
    assign last_byte = (byte_cnt_q == BC_W'(BYTES - 1));
    // word_count already includes the word being strobed, so this fires during the final wr_en
    assign load_end  = wr_en_q && (word_count_q == len_q);

    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            state_q      <= L_IDLE;
            word_q       <= '0;
            byte_cnt_q   <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            load_done_q  <= 1'b0;
            word_count_q <= '0;
            err_q        <= 2'b00;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            word_q       <= word_d;
            byte_cnt_q   <= byte_cnt_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            load_done_q  <= load_done_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        if (frame_err_q) begin
            state_d = L_IDLE;
        end else begin
            case (state_q)
                L_IDLE, L_DONE: if (hdr_seen) state_d = hdr_bad ? L_IDLE : L_DATA;
`ifdef LOADER_CHECKSUM_EN
                L_DATA: if (load_end) state_d = L_CSUM;
                L_CSUM: if (accept) state_d = (shift_q == csum_q) ? L_DONE : L_IDLE;
`else
                L_DATA: if (load_end) state_d = L_DONE;
`endif
                default: state_d = L_IDLE;
            endcase
        end
    end

    always_comb begin
        word_d       = word_q;
        byte_cnt_d   = byte_cnt_q;
        addr_d       = addr_q;
        len_d        = len_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        load_done_d  = load_done_q;
        word_count_d = word_count_q;
        err_d        = err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        if (frame_err_q) begin
            err_d       = 2'b01;
            load_done_d = 1'b0;
        end else begin
            case (state_q)
                L_IDLE, L_DONE: begin
                    if (hdr_seen) begin
                        load_done_d  = 1'b0;
                        word_count_d = '0;
                        if (hdr_bad) begin
                            err_d = 2'b10;
                        end else begin
                            err_d      = 2'b00;
                            byte_cnt_d = '0;
                            addr_d     = '0;
                            len_d      = (ADDR_W + 1)'(shift_q);
`ifdef LOADER_CHECKSUM_EN
                            csum_d     = '0;
`endif
                        end
                    end
                end
                L_DATA: begin
                    if (accept) begin
                        word_d = (word_q << 8) | INSTR_WIDTH'(shift_q);
`ifdef LOADER_CHECKSUM_EN
                        csum_d = csum_q ^ shift_q;
`endif
                        if (last_byte) begin
                            byte_cnt_d   = '0;
                            wr_en_d      = 1'b1;
                            wr_addr_d    = addr_q;
                            wr_data_d    = word_d;
                            word_count_d = word_count_q + 1'b1;
                            addr_d       = addr_q + 1'b1;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 1'b1;
                        end
                    end
`ifndef LOADER_CHECKSUM_EN
                    else if (load_end) begin
                        load_done_d = 1'b1;
                    end
`endif
                end
`ifdef LOADER_CHECKSUM_EN
                L_CSUM: begin
                    if (accept) begin
                        if (shift_q == csum_q) load_done_d = 1'b1;
                        else                   err_d       = 2'b11;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign err_code   = err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader: serial stimulus, write scoreboard and status checks.
// Follows LOADER_CHECKSUM_EN to append checksum bytes and exercise the matching checks.
module tb_uart_program_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;
    logic        load_done;
    logic [5:0]  word_count;
    logic [1:0]  err_code;

    uart_program_loader #(
        .CLK_FREQ_HZ(1000000),
        .BAUD(100000),
        .INSTR_WIDTH(16),
        .DEPTH(32),
        .ADDR_W(5)
    ) dut (
        .CLK(clk),
        .CPU_RESETN(rst_n),
        .UART_TXD_IN(rxd),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .load_done(load_done),
        .word_count(word_count),
        .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_wr_cyc = -100;
    int          ld_rise_cyc = -100;
    logic        prev_wr = 1'b0;
    logic        prev_ld = 1'b0;
    logic [15:0] wbuf[32];

    always @(posedge clk) cyc <= cyc + 1;

    // write monitor: every strobe must match the next scoreboard entry
    always @(negedge clk) begin : mon
        wr_t e;
        if (wr_en) begin
            total++;
            assert (!prev_wr) else begin
                bad++;
                $error("FAIL wr_back_to_back observed=1 expected=0");
            end
            total++;
            assert (exp_q.size() != 0) else begin
                bad++;
                $error("FAIL wr_unexpected observed addr=%0d data=%h expected=none", wr_addr, wr_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                assert ({wr_addr, wr_data} === e) else begin
                    bad++;
                    $error("FAIL wr_word observed addr=%0d data=%h expected addr=%0d data=%h",
                           wr_addr, wr_data, e.a, e.d);
                end
            end
            last_wr_cyc = cyc;
        end
        prev_wr = wr_en;
        if (load_done && !prev_ld) ld_rise_cyc = cyc;
        prev_ld = load_done;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rxd = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (10) @(negedge clk);
        end
        rxd = stop;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // data bytes of wbuf[0..n-1]; expected writes queued before the word's last byte goes out
    task automatic load_body(input int n, input logic [7:0] csum_adj);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            x = x ^ wbuf[i][15:8] ^ wbuf[i][7:0];
            send_byte(wbuf[i][15:8], 1'b1);
            exp_q.push_back(wr_t'{a: 5'(i), d: wbuf[i]});
            send_byte(wbuf[i][7:0], 1'b1);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(x ^ csum_adj, 1'b1);
`else
        if (csum_adj != 8'h00) x = 8'h00;
`endif
    endtask

    task automatic load(input int n, input logic [7:0] csum_adj);
        send_byte(8'(n), 1'b1);
        load_body(n, csum_adj);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_word_count"}, 32'(word_count), 32'd0);
        chk({tag, "_err_code"}, 32'(err_code), 32'd0);
    endtask

    task automatic chk_status(input string tag, input logic ld, input int wc, input logic [1:0] ec);
        chk({tag, "_load_done"}, 32'(load_done), 32'(ld));
        chk({tag, "_word_count"}, 32'(word_count), 32'(wc));
        chk({tag, "_err_code"}, 32'(err_code), 32'(ec));
    endtask

    task automatic chk_ld_timing(input string tag);
`ifdef LOADER_CHECKSUM_EN
        chk(tag, 32'(ld_rise_cyc > last_wr_cyc), 32'd1);
`else
        chk(tag, 32'(ld_rise_cyc), 32'(last_wr_cyc + 1));
`endif
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // basic two-word load
        wbuf[0] = 16'h1234;
        wbuf[1] = 16'hABCD;
        load(2, 8'h00);
        chk_status("basic", 1'b1, 2, 2'b00);
        chk_ld_timing("basic_ld_timing");

        // reload without reset
        send_byte(8'h01, 1'b1);
        chk_status("reload_hdr", 1'b0, 0, 2'b00);
        wbuf[0] = 16'h55AA;
        load_body(1, 8'h00);
        chk_status("reload", 1'b1, 1, 2'b00);
        chk_ld_timing("reload_ld_timing");

        // short glitch and zero header leave a finished load untouched
        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (120) @(negedge clk);
        chk_status("glitch", 1'b1, 1, 2'b00);
        send_byte(8'h00, 1'b1);
        chk_status("hdr_zero", 1'b1, 1, 2'b00);

        // framing error mid-load, then recovery
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b0);
        chk_status("framing", 1'b0, 0, 2'b01);
        wbuf[0] = 16'h0007;
        load(1, 8'h00);
        chk_status("after_framing", 1'b1, 1, 2'b00);

        // length one past DEPTH
        send_byte(8'h21, 1'b1);
        chk_status("bad_len", 1'b0, 0, 2'b10);

        // length exactly DEPTH
        for (int i = 0; i < 32; i++) wbuf[i] = 16'(i * 257) ^ 16'hA5C3;
        load(32, 8'h00);
        chk_status("full_depth", 1'b1, 32, 2'b00);
        chk_ld_timing("full_depth_ld_timing");

        // reset after first data byte
        send_byte(8'h02, 1'b1);
        send_byte(8'h12, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midload_reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        wbuf[0] = 16'hBEEF;
        load(1, 8'h00);
        chk_status("after_reset", 1'b1, 1, 2'b00);

        // single word with (or without) trailing checksum
        wbuf[0] = 16'h1234;
        load(1, 8'h00);
        chk_status("csum_good", 1'b1, 1, 2'b00);
`ifdef LOADER_CHECKSUM_EN
        load(1, 8'h01);
        chk_status("csum_bad", 1'b0, 1, 2'b11);
`endif

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
# uart_program_loader

Parametrised serial boot loader that fills the processor's instruction memory over `UART_TXD_IN` and releases the PC with `load_done`. It generalises the fixed 16-bit, 32-entry UART load path to any instruction width and depth. It adds a length header, error reporting, reload-without-reset and an optional checksum. It sits between the board UART pin and the instruction memory write port, and drives the `load_done` input of `PC_control`.

## Interface
- `CLK_FREQ_HZ`, 100000000, system clock frequency
- `BAUD`, 115200, line rate; bit period `DIV = CLK_FREQ_HZ/BAUD` cycles (integer division, `DIV >= 4`)
- `INSTR_WIDTH`, 16, instruction word width; multiple of 8, `>= 8`
- `DEPTH`, 32, instruction memory words; `2 <= DEPTH <= 255`
- `ADDR_W`, 5, write address width; `2**ADDR_W >= DEPTH`
- `CLK` in 1: system clock; all logic on the rising edge
- `CPU_RESETN` in 1: synchronous, active-low reset
- `UART_TXD_IN` in 1: asynchronous serial input, 8N1, LSB first, idle high
- `wr_en` out 1: one-cycle instruction memory write strobe
- `wr_addr` out `ADDR_W`: write address
- `wr_data` out `INSTR_WIDTH`: write data
- `load_done` out 1: program loaded and valid; PC may run
- `word_count` out `ADDR_W+1`: number of words written in the current or last load
- `err_code` out 2: 00 none, 01 framing, 10 bad length, 11 checksum; sticky

## Operation
- Receiver:
  - 2-flop synchroniser on `UART_TXD_IN`.
  - In RX_IDLE, a sampled 1→0 edge starts the bit counter. The line is re-sampled at `DIV/2`; if it is high, the event is treated as a glitch and the receiver returns to RX_IDLE.
  - The 8 data bits are then sampled every `DIV` cycles, LSB first, followed by the stop bit.
  - Stop bit = 1: `byte_valid` pulses one cycle with the byte.
  - Stop bit = 0: framing error.
- Loader FSM states: L_IDLE, L_DATA, L_CSUM, L_DONE.
- **L_IDLE / L_DONE: header byte `N`**
  - `N == 0`: ignored; state unchanged.
  - `N > DEPTH`: `err_code=10`; `load_done` and `word_count` are cleared; go to L_IDLE.
  - Otherwise: clear `err_code`, `load_done`, `word_count`, byte counter and address; go to L_DATA.
- **L_DATA**
  - Bytes are shifted into the word MSB first; each word is `INSTR_WIDTH/8` bytes.
  - On the last byte of a word, the next cycle asserts `wr_en` with `wr_data` = word and `wr_addr` = current address. `word_count` increments in the same cycle, and the address increments after the write.
  - After word `N` is written, go to L_CSUM if checksum is compiled in, otherwise go to L_DONE.
- **L_DONE**: `load_done=1` is held until reset or until the next accepted header.
- **Framing error in any loader state**: the byte is discarded, `err_code=01`, `load_done=0`, go to L_IDLE. Words already written stay in memory; `word_count` keeps its value.
- Every loader state ignores bytes that arrive while `wr_en` is being issued; this cannot occur because a byte takes at least `10*DIV` cycles.
- Addresses never wrap: the length check guarantees `wr_addr <= DEPTH-1`.

## Timing
- Reset values (the cycle after `CPU_RESETN` is sampled low):
  - `wr_en=0`, `wr_addr=0`, `wr_data=0`, `load_done=0`, `word_count=0`, `err_code=00`.
  - Receiver in RX_IDLE; loader in L_IDLE.
- Reset mid-byte or mid-load aborts immediately, and partial state is discarded. A byte already in flight on the line is not recovered; it is only seen again at its next falling edge.
- `byte_valid` is asserted 1 cycle after the mid-stop-bit sample, i.e. about `9.5*DIV + 3` cycles after the start edge on the pin.
- `wr_en` is asserted exactly 1 cycle after the `byte_valid` of the word's last byte, and is never high on two consecutive cycles.
- `load_done` rises:
  - without checksum: the cycle after the final `wr_en`;
  - with checksum: the cycle after the checksum byte's `byte_valid`.
- Error outputs update in the cycle after the offending byte or stop-bit sample.

## Configuration
- Macro: `LOADER_CHECKSUM_EN`.
- **Defined**
  - The loader keeps an XOR of all data bytes; the header is not included.
  - After word `N`, L_CSUM waits for one more byte.
  - If the byte equals the XOR: go to L_DONE.
  - If it differs: `err_code=11`, `load_done` stays 0, go to L_IDLE.
- **Undefined**
  - The L_CSUM state and the XOR register are not built.
  - L_DATA goes directly to L_DONE, and no trailing byte is expected.

## Test plan
The bench uses `CLK_FREQ_HZ=1000000`, `BAUD=100000` (`DIV=10`), `INSTR_WIDTH=16`, `DEPTH=32`, `ADDR_W=5`.

- **Basic load**: send `0x02 0x12 0x34 0xAB 0xCD` → `wr_en` at addr 0 with `0x1234`, then at addr 1 with `0xABCD` → `word_count=2`, `load_done=1` one cycle after the second write, `err_code=00`.
- **Framing error**: send `0x02 0x12`, then a byte with stop bit 0 → `err_code=01`, `load_done=0`, no further `wr_en`. A following `0x01 0x00 0x07` writes `0x0007` at addr 0 and clears `err_code`.
- **Bad length and glitch**: header `0x21` → `err_code=10`, no `wr_en`. A 3-cycle low glitch on the line produces no `byte_valid`. Header `0x00` causes no state change.
- **Checksum (macro defined)**:
  - `0x01 0x12 0x34 0x26` → `load_done=1`.
  - `0x01 0x12 0x34 0x27` → `err_code=11`, `load_done=0`.
  - Macro undefined: `0x01 0x12 0x34` alone → `load_done=1`.
- **Reset mid-load**: assert `CPU_RESETN=0` for 1 cycle after the first data byte of `0x02…` → all outputs are 0 the next cycle. A fresh `0x01 0xBE 0xEF` writes `0xBEEF` at addr 0.
- **Reload without reset**: after the basic load, send `0x01 0x55 0xAA` → `load_done` falls the cycle after the header byte's `byte_valid`, `word_count=0`. Then a write of `0x55AA` at addr 0, `word_count=1`, and `load_done` rises again.
